// File: rtl/prng_word_packer_if.sv
// prng_word_packer_if
//   Output word stream of the PRNG word packer as a valid/ready handshake.
//   Ports (grouped signals):
//     out_data  [W-1:0]  head word of the packer FIFO, 0 when empty
//     out_valid          FIFO holds at least one word
//     out_ready          consumer accepts out_data this cycle
//   Modports:
//     master  - the packer (drives data/valid, samples ready)
//     slave   - the consumer (samples data/valid, drives ready)
interface prng_word_packer_if #(
    parameter int W = 8
);
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/prng_word_packer.sv
// prng_word_packer
//   Samples the MSB of an upstream LFSR once per enabled clock, packs the
//   bits MSB-first into W-bit words and buffers completed words in a
//   DEPTH-entry FIFO presented on a valid/ready stream. Flags FIFO overflow
//   (a completed word had no room) and LFSR lock-up (all-zero state sampled).
//   Ports:
//     clk       rising-edge clock
//     r         asynchronous active-high reset, clears every register
//     en        sample enable, consumes lfsr_q[N-1]
//     flush     synchronous; drops the partial word and empties the FIFO
//     lfsr_q    LFSR state bus
//     out_if    word stream (master side)
//     level     number of words held in the FIFO
//     overflow  sticky, a completed word was dropped
//     stuck     sticky, lfsr_q == 0 sampled with en = 1
module prng_word_packer #(
    parameter int N     = 26,
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         r,
    input  logic                         en,
    input  logic                         flush,
    input  logic [N-1:0]                 lfsr_q,
    prng_word_packer_if.master           out_if,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         overflow,
    output logic                         stuck
);
    localparam int CNT_W = $clog2(W);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(W - 1);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_ONE   = LVL_W'(1);

    logic [W-1:0]     shreg;
    logic [CNT_W-1:0] cnt;
    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [W-1:0]     head_q;
    logic             valid_q;

    logic [W-1:0]     word;
    logic             complete;
    logic             pop;
    logic             full;
    logic             push;
    logic             drop;
    logic [PTR_W-1:0] rd_next;
    logic [LVL_W-1:0] level_nxt;
    logic [W-1:0]     head_nxt;

    assign out_if.out_data  = head_q;
    assign out_if.out_valid = valid_q;

    assign word     = {shreg[W-2:0], lfsr_q[N-1]};
    assign complete = en && (cnt == CNT_LAST);
    assign pop      = valid_q && out_if.out_ready;
    assign full     = (level == LVL_FULL);
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign push     = complete && (!full || pop);
    assign drop     = complete && full && !pop;
    assign rd_next  = rd_ptr + 1'b1;

    always_comb begin
        level_nxt = level;
        case ({push, pop})
            2'b10:   level_nxt = level + 1'b1;
            2'b01:   level_nxt = level - 1'b1;
            default: level_nxt = level;
        endcase
    end

    // The head word is kept in its own register so out_data is fully
    // registered. When the last stored word is popped while a new one is
    // pushed, the new word becomes the head directly.
    always_comb begin
        head_nxt = head_q;
        if (pop) begin
            if (level > LVL_ONE) begin
                head_nxt = mem[rd_next];
            end else if (push) begin
                head_nxt = word;
            end else begin
                head_nxt = '0;
            end
        end else if (push && (level == '0)) begin
            head_nxt = word;
        end
    end

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            shreg    <= '0;
            cnt      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
            overflow <= 1'b0;
            stuck    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (en && (lfsr_q == '0)) begin
                stuck <= 1'b1;
            end
            if (flush) begin
                shreg   <= '0;
                cnt     <= '0;
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                level   <= '0;
                head_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                if (en) begin
                    shreg <= word;
                    cnt   <= complete ? '0 : cnt + 1'b1;
                end
                if (push) begin
                    mem[wr_ptr] <= word;
                    wr_ptr      <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_next;
                end
                if (drop) begin
                    overflow <= 1'b1;
                end
                level   <= level_nxt;
                valid_q <= (level_nxt != '0);
                head_q  <= head_nxt;
            end
        end
    end
endmodule

// File: tb/tb_prng_word_packer.sv
module tb_prng_word_packer;
    localparam int N     = 26;
    localparam int W     = 8;
    localparam int DEPTH = 4;

    logic         clk;
    logic         r;
    logic         en;
    logic         flush;
    logic [N-1:0] lfsr_q;
    logic [2:0]   level;
    logic         overflow;
    logic         stuck;

    prng_word_packer_if #(.W(W)) out_if ();

    prng_word_packer #(.N(N), .W(W), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .r        (r),
        .en       (en),
        .flush    (flush),
        .lfsr_q   (lfsr_q),
        .out_if   (out_if.master),
        .level    (level),
        .overflow (overflow),
        .stuck    (stuck)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: bit accumulator plus a queue of expected FIFO words.
    logic [W-1:0] sb [$];
    logic [W-1:0] m_acc;
    int           m_cnt;
    logic         m_ovf;
    logic         m_stuck;

    task automatic model_reset();
        sb.delete();
        m_acc   = '0;
        m_cnt   = 0;
        m_ovf   = 1'b0;
        m_stuck = 1'b0;
    endtask

    // Drives one clock of stimulus, updates the model, checks pops against
    // the scoreboard and level/overflow/stuck after the edge.
    task automatic step(input logic e, input logic b, input logic rdy,
                        input logic fl, input logic zero);
        logic [N-2:0] rnd;
        logic [W-1:0] exp_w;
        logic         popped;
        rnd = (N-1)'($urandom) | (N-1)'(1);
        en              = e;
        flush           = fl;
        out_if.out_ready = rdy;
        lfsr_q          = zero ? '0 : {b, rnd};
        popped          = 1'b0;
        n_tests++;
        if (out_if.out_valid !== (sb.size() != 0)) begin
            n_fail++;
            $display("FAIL valid_pre: got %0b want %0b", out_if.out_valid, sb.size() != 0);
        end
        if (e && zero) m_stuck = 1'b1;
        if (fl) begin
            sb.delete();
            m_acc = '0;
            m_cnt = 0;
        end else begin
            if (out_if.out_valid && rdy) begin
                popped = 1'b1;
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL pop_empty: got %h want no pop", out_if.out_data);
                end else begin
                    exp_w = sb.pop_front();
                    if (out_if.out_data !== exp_w) begin
                        n_fail++;
                        $display("FAIL pop_data: got %h want %h", out_if.out_data, exp_w);
                    end
                end
            end
            if (e) begin
                m_acc = {m_acc[W-2:0], (zero ? 1'b0 : b)};
                m_cnt++;
                if (m_cnt == W) begin
                    m_cnt = 0;
                    if (sb.size() < DEPTH) sb.push_back(m_acc);
                    else m_ovf = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (level !== 3'(sb.size())) begin
            n_fail++;
            $display("FAIL level: got %0d want %0d", level, sb.size());
        end
        n_tests++;
        if (overflow !== m_ovf || stuck !== m_stuck) begin
            n_fail++;
            $display("FAIL flags: got ovf=%0b stuck=%0b want ovf=%0b stuck=%0b",
                     overflow, stuck, m_ovf, m_stuck);
        end
        n_tests++;
        if (sb.size() == 0 && out_if.out_data !== '0) begin
            n_fail++;
            $display("FAIL empty_data: got %h want 0", out_if.out_data);
        end
    endtask

    task automatic pack_word(input logic [W-1:0] w, input logic rdy);
        for (int i = W - 1; i >= 0; i--) step(1'b1, w[i], rdy, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        r = 1'b1;
        en = 1'b0;
        flush = 1'b0;
        out_if.out_ready = 1'b0;
        lfsr_q = '1;
        model_reset();
        @(posedge clk);
        #3;
        r = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (out_if.out_data !== '0 || out_if.out_valid !== 1'b0 || level !== 3'd0 ||
            overflow !== 1'b0 || stuck !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: got data=%h v=%0b lvl=%0d ovf=%0b stk=%0b want all 0",
                     out_if.out_data, out_if.out_valid, level, overflow, stuck);
        end
    endtask

    task automatic test_pack_order();
        pack_word(8'hB2, 1'b1);
        n_tests++;
        if (out_if.out_data !== 8'hB2 || out_if.out_valid !== 1'b1 || level !== 3'd1) begin
            n_fail++;
            $display("FAIL pack_order: got data=%h v=%0b lvl=%0d want b2 1 1",
                     out_if.out_data, out_if.out_valid, level);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (level !== 3'd0) begin
            n_fail++;
            $display("FAIL pack_pop: got lvl=%0d want 0", level);
        end
    endtask

    task automatic test_pause();
        logic [W-1:0] w;
        w = 8'hB2;
        for (int i = W - 1; i >= W - 3; i--) step(1'b1, w[i], 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            n_tests++;
            if (out_if.out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL pause_valid: got %0b want 0 at pause %0d", out_if.out_valid, k);
            end
        end
        for (int i = W - 4; i >= 1; i--) begin
            step(1'b1, w[i], 1'b1, 1'b0, 1'b0);
            n_tests++;
            if (out_if.out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL pause_early: got %0b want 0", out_if.out_valid);
            end
        end
        step(1'b1, w[0], 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (out_if.out_data !== 8'hB2 || out_if.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL pause_word: got %h v=%0b want b2 1", out_if.out_data, out_if.out_valid);
        end
        drain();
    endtask

    task automatic test_overflow();
        for (int k = 0; k < 4; k++) pack_word(W'($urandom), 1'b0);
        n_tests++;
        if (level !== 3'd4 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_fill: got lvl=%0d ovf=%0b want 4 0", level, overflow);
        end
        pack_word(W'($urandom), 1'b0);
        n_tests++;
        if (level !== 3'd4 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_drop: got lvl=%0d ovf=%0b want 4 1", level, overflow);
        end
        w_last_bits();
        n_tests++;
        if (level !== 3'd4) begin
            n_fail++;
            $display("FAIL ovf_pushpop: got lvl=%0d want 4", level);
        end
        drain();
    endtask

    // Sixth word: ready held low for 7 bits, raised on the completion edge.
    task automatic w_last_bits();
        logic [W-1:0] w;
        w = W'($urandom);
        for (int i = W - 1; i >= 1; i--) step(1'b1, w[i], 1'b0, 1'b0, 1'b0);
        step(1'b1, w[0], 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_flush();
        pack_word(W'($urandom), 1'b0);
        pack_word(W'($urandom), 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'($urandom), 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (level !== 3'd2) begin
            n_fail++;
            $display("FAIL flush_pre: got lvl=%0d want 2", level);
        end
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        n_tests++;
        if (level !== 3'd0 || out_if.out_valid !== 1'b0 || out_if.out_data !== '0 ||
            overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL flush: got lvl=%0d v=%0b data=%h ovf=%0b want 0 0 0 1",
                     level, out_if.out_valid, out_if.out_data, overflow);
        end
        pack_word(8'h5A, 1'b0);
        n_tests++;
        if (out_if.out_data !== 8'h5A) begin
            n_fail++;
            $display("FAIL flush_fresh: got %h want 5a", out_if.out_data);
        end
        drain();
    endtask

    task automatic test_stuck();
        do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        n_tests++;
        if (stuck !== 1'b0) begin
            n_fail++;
            $display("FAIL stuck_noen: got %0b want 0", stuck);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        n_tests++;
        if (stuck !== 1'b1) begin
            n_fail++;
            $display("FAIL stuck_set: got %0b want 1", stuck);
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        n_tests++;
        if (stuck !== 1'b1) begin
            n_fail++;
            $display("FAIL stuck_flush: got %0b want 1", stuck);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int k = 0; k < 3; k++) pack_word(W'($urandom), 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom), 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (level !== 3'd3) begin
            n_fail++;
            $display("FAIL areset_pre: got lvl=%0d want 3", level);
        end
        en = 1'b1;
        out_if.out_ready = 1'b1;
        #2;
        r = 1'b1;
        #1;
        n_tests++;
        if (out_if.out_data !== '0 || out_if.out_valid !== 1'b0 || level !== 3'd0 ||
            overflow !== 1'b0 || stuck !== 1'b0) begin
            n_fail++;
            $display("FAIL areset: got data=%h v=%0b lvl=%0d ovf=%0b stk=%0b want all 0",
                     out_if.out_data, out_if.out_valid, level, overflow, stuck);
        end
        #1;
        r = 1'b0;
        model_reset();
        pack_word(8'hC3, 1'b1);
        n_tests++;
        if (out_if.out_data !== 8'hC3 || level !== 3'd1) begin
            n_fail++;
            $display("FAIL areset_word: got %h lvl=%0d want c3 1", out_if.out_data, level);
        end
        drain();
    endtask

    initial begin
        r = 1'b1;
        en = 1'b0;
        flush = 1'b0;
        lfsr_q = '1;
        out_if.out_ready = 1'b0;
        model_reset();
        test_reset();
        test_pack_order();
        test_pause();
        test_overflow();
        test_flush();
        test_stuck();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
